// File: rtl/spio_spinnaker_link_pkg.sv
// spio_spinnaker_link_pkg: shared 2-of-7 symbol table, EOP symbol, packet field ranges, flit counts and tx FSM states
package spio_spinnaker_link_pkg;
  typedef enum logic [1:0] {WAIT_LINK, IDLE, SEND} tx_state_t;
  localparam logic [6:0] SYM_TABLE [16] = '{
    7'b0010001, 7'b0010010, 7'b0010100, 7'b0011000,
    7'b0100001, 7'b0100010, 7'b0100100, 7'b0101000,
    7'b1000001, 7'b1000010, 7'b1000100, 7'b1001000,
    7'b0000011, 7'b0000110, 7'b0001100, 7'b0001001
  };
  localparam logic [6:0] EOP_SYM = 7'b1100000;
  localparam int HDR_LSB = 0;
  localparam int HDR_MSB = 7;
  localparam int KEY_LSB = 8;
  localparam int KEY_MSB = 39;
  localparam int PLD_LSB = 40;
  localparam int PLD_MSB = 71;
  localparam int HDR_LONG_BIT = 1;
  localparam logic [4:0] FLITS_SHORT = 5'd10;
  localparam logic [4:0] FLITS_LONG = 5'd18;
endpackage

// File: rtl/spio_spinnaker_link_ack_sync.sv
// spio_spinnaker_link_ack_sync: SYNC_STAGES-deep synchronizer (clk, rst, async ack in, ack_s out)
module spio_spinnaker_link_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ack,
  output logic ack_s
);
  logic [SYNC_STAGES-1:0] sr;
  always_ff @(posedge clk)
    sr <= rst ? '0 : {sr[SYNC_STAGES-2:0], ack};
  assign ack_s = sr[SYNC_STAGES-1];
endmodule

// File: rtl/spio_spinnaker_link_synchronous_transmitter.sv
// spio_spinnaker_link_synchronous_transmitter: 72-bit packet in (data/vld/rdy) -> NRZ 2-of-7 link flits out, async transition ack in
module spio_spinnaker_link_synchronous_transmitter
  import spio_spinnaker_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic [71:0] PKT_DATA_IN,
  input  logic        PKT_VLD_IN,
  output logic        PKT_RDY_OUT,
  output logic [6:0]  SL_DATA_2OF7_OUT,
  input  logic        SL_ACK_IN
);
  tx_state_t   state;
  logic [71:0] pkt;
  logic [4:0]  cnt;
  logic        full, busy, ack_ref, ack_s;
  logic        ack_chg, can_send, last, accept;
  logic [6:0]  sym;
  spio_spinnaker_link_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (CLK_IN),
    .rst   (RESET_IN),
    .ack   (SL_ACK_IN),
    .ack_s (ack_s)
  );
  assign PKT_RDY_OUT = (state != WAIT_LINK) && !full;
  assign accept      = PKT_VLD_IN && PKT_RDY_OUT;
  assign ack_chg     = ack_s != ack_ref;
  assign can_send    = !busy || ack_chg;
  assign last        = cnt == (pkt[HDR_LONG_BIT] ? FLITS_LONG : FLITS_SHORT);
  assign sym         = last ? EOP_SYM : SYM_TABLE[pkt[{cnt, 2'b00} +: 4]];
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state            <= WAIT_LINK;
      pkt              <= '0;
      cnt              <= '0;
      full             <= 1'b0;
      busy             <= 1'b1;
      ack_ref          <= 1'b0;
      SL_DATA_2OF7_OUT <= '0;
    end else begin
      if (accept) begin
        pkt  <= PKT_DATA_IN;
        full <= 1'b1;
      end
      if (state == WAIT_LINK) begin
        if (ack_s) begin
          busy    <= 1'b0;
          ack_ref <= 1'b1;
          state   <= IDLE;
        end
      end else begin
        if (ack_chg) begin
          ack_ref <= ack_s;
          busy    <= 1'b0;
        end
        // An ack seen this cycle frees the link, so the next flit goes out without waiting for busy to drop
        if (full && can_send) begin
          SL_DATA_2OF7_OUT <= SL_DATA_2OF7_OUT ^ sym;
          busy             <= 1'b1;
          cnt              <= last ? 5'd0 : cnt + 5'd1;
          full             <= !last;
          state            <= last ? IDLE : SEND;
        end
      end
    end
  end
endmodule

// File: tb/tb_spio_spinnaker_link_synchronous_transmitter.sv
// tb_spio_spinnaker_link_synchronous_transmitter: directed self-checking bench with a remote receiver model
module tb_spio_spinnaker_link_synchronous_transmitter;
  localparam int SYNC_STAGES = 2;
  localparam logic [6:0] EOP = 7'b1100000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        ack = 1'b0;
  logic        rdy;
  logic [71:0] pdata = '0;
  logic [6:0]  sl;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [6:0] got [24];
  logic [6:0] got_v [24];
  int got_t [24];
  int got_n = 0;
  spio_spinnaker_link_synchronous_transmitter #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK_IN           (clk),
    .RESET_IN         (rst),
    .PKT_DATA_IN      (pdata),
    .PKT_VLD_IN       (vld),
    .PKT_RDY_OUT      (rdy),
    .SL_DATA_2OF7_OUT (sl),
    .SL_ACK_IN        (ack)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b0010001;
      4'h1: enc = 7'b0010010;
      4'h2: enc = 7'b0010100;
      4'h3: enc = 7'b0011000;
      4'h4: enc = 7'b0100001;
      4'h5: enc = 7'b0100010;
      4'h6: enc = 7'b0100100;
      4'h7: enc = 7'b0101000;
      4'h8: enc = 7'b1000001;
      4'h9: enc = 7'b1000010;
      4'ha: enc = 7'b1000100;
      4'hb: enc = 7'b1001000;
      4'hc: enc = 7'b0000011;
      4'hd: enc = 7'b0000110;
      4'he: enc = 7'b0001100;
      default: enc = 7'b0001001;
    endcase
  endfunction
  function automatic logic [3:0] dec(input logic [6:0] s);
    for (int v = 0; v < 16; v++) begin
      logic [3:0] n;
      n = v[3:0];
      if (enc(n) === s) return n;
    end
    return 4'hx;
  endfunction
  function automatic logic [71:0] reasm(input int nn);
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < nn; i++) r[4*i +: 4] = dec(got[i]);
    return r;
  endfunction
  task automatic send_pkt(input logic [71:0] p, output int acc);
    int t;
    t = 0;
    while (!rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_err++;
      $display("FAIL send_rdy: rdy=%b required 1", rdy);
    end
    pdata = p;
    vld = 1'b1;
    @(negedge clk);
    acc = cyc;
    vld = 1'b0;
  endtask
  task automatic rx(input int n, input bit ack_last);
    logic [6:0] prev;
    int t;
    got_n = 0;
    prev = sl;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (sl === prev && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (sl === prev) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_timeout: flit %0d got no change in %0d cycles, required a flit", i, t);
        return;
      end
      got[i] = sl ^ prev;
      got_v[i] = sl;
      got_t[i] = cyc;
      got_n++;
      prev = sl;
      if (i < n - 1 || ack_last) ack = ~ack;
    end
  endtask
  task automatic test_reset;
    int t;
    rst = 1'b1;
    ack = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rdy !== 1'b0 || sl !== 7'b0) begin
      n_err++;
      $display("FAIL reset_hold: rdy=%b data=%b required 0/0000000", rdy, sl);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (rdy !== 1'b0) begin
      n_err++;
      $display("FAIL wait_link_rdy: rdy=%b required 0", rdy);
    end
    n_cmp++;
    if (sl !== 7'b0) begin
      n_err++;
      $display("FAIL wait_link_data: data=%b required 0000000", sl);
    end
    ack = 1'b1;
    t = 0;
    while (!rdy && t < SYNC_STAGES + 2) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_err++;
      $display("FAIL link_up_rdy: rdy=%b after %0d cycles required 1", rdy, t);
    end
  endtask
  task automatic test_short;
    logic [71:0] p;
    logic [6:0] v;
    int acc;
    p = {32'hdeadbeef, 32'h00000001, 8'h00};
    send_pkt(p, acc);
    rx(11, 1'b1);
    n_cmp++;
    if (got_n != 11) begin
      n_err++;
      $display("FAIL short_count: flits=%0d required 11", got_n);
    end
    n_cmp++;
    if (got_t[0] - acc != 1) begin
      n_err++;
      $display("FAIL short_flit0_latency: %0d cycles required 1", got_t[0] - acc);
    end
    n_cmp++;
    if (got_v[0] !== 7'b0010001 || got_v[1] !== 7'b0000000 || got_v[2] !== 7'b0010010) begin
      n_err++;
      $display("FAIL short_first_wires: %b %b %b required 0010001 0000000 0010010", got_v[0], got_v[1], got_v[2]);
    end
    for (int i = 0; i < got_n; i++) begin
      n_cmp++;
      if (got[i] !== (i < 10 ? enc(p[4*i +: 4]) : EOP)) begin
        n_err++;
        $display("FAIL short_flit%0d: xor=%b required %b", i, got[i], i < 10 ? enc(p[4*i +: 4]) : EOP);
      end
    end
    v = sl;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (sl !== v || rdy !== 1'b1) begin
      n_err++;
      $display("FAIL short_idle_after_eop: data=%b rdy=%b required %b/1", sl, rdy, v);
    end
    n_cmp++;
    if (reasm(10) !== {32'h0, p[39:0]}) begin
      n_err++;
      $display("FAIL short_reasm: %h required %h", reasm(10), {32'h0, p[39:0]});
    end
  endtask
  task automatic test_long;
    logic [71:0] p;
    logic [3:0] e;
    int acc;
    p = {32'ha5a5a5a5, 32'h12345678, 8'h02};
    send_pkt(p, acc);
    rx(19, 1'b1);
    n_cmp++;
    if (got_n != 19) begin
      n_err++;
      $display("FAIL long_count: flits=%0d required 19", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      n_cmp++;
      if (got[i] !== (i < 18 ? enc(p[4*i +: 4]) : EOP)) begin
        n_err++;
        $display("FAIL long_flit%0d: xor=%b required %b", i, got[i], i < 18 ? enc(p[4*i +: 4]) : EOP);
      end
    end
    for (int i = 10; i < 18 && i < got_n; i++) begin
      e = (i % 2 == 0) ? 4'h5 : 4'ha;
      n_cmp++;
      if (dec(got[i]) !== e) begin
        n_err++;
        $display("FAIL long_payload_nibble%0d: %h required %h", i, dec(got[i]), e);
      end
    end
    n_cmp++;
    if (reasm(18) !== p) begin
      n_err++;
      $display("FAIL long_reasm: %h required %h", reasm(18), p);
    end
  endtask
  task automatic test_stall;
    logic [71:0] p;
    logic [6:0] v;
    bit stable;
    int acc, c;
    p = {32'h0, 32'hcafef00d, 8'h40};
    send_pkt(p, acc);
    rx(4, 1'b0);
    v = sl;
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (sl !== v) stable = 1'b0;
    end
    n_cmp++;
    if (!stable || got_n != 4) begin
      n_err++;
      $display("FAIL stall_hold: stable=%b flits=%0d required 1/4", stable, got_n);
    end
    ack = ~ack;
    c = cyc;
    rx(7, 1'b1);
    n_cmp++;
    if (got_n < 1 || got_t[0] - c != SYNC_STAGES + 1) begin
      n_err++;
      $display("FAIL stall_resume_latency: %0d cycles required %0d", got_n < 1 ? -1 : got_t[0] - c, SYNC_STAGES + 1);
    end
    for (int i = 0; i < got_n; i++) begin
      n_cmp++;
      if (got[i] !== (i < 6 ? enc(p[4*(i+4) +: 4]) : EOP)) begin
        n_err++;
        $display("FAIL stall_flit%0d: xor=%b required %b", i + 4, got[i], i < 6 ? enc(p[4*(i+4) +: 4]) : EOP);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [71:0] a, b, ra;
    int t, t_eop;
    a = {32'h11111111, 32'h89abcdef, 8'h10};
    b = {32'h0f1e2d3c, 32'h4b5a6978, 8'h02};
    t = 0;
    while (!rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    pdata = a;
    vld = 1'b1;
    @(negedge clk);
    pdata = b;
    rx(11, 1'b1);
    ra = reasm(10);
    t_eop = got_n == 11 ? got_t[10] : -100;
    n_cmp++;
    if (got_n != 11 || got[10] !== EOP) begin
      n_err++;
      $display("FAIL b2b_a_eop: flits=%0d last=%b required 11/%b", got_n, got[got_n > 0 ? got_n - 1 : 0], EOP);
    end
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_rdy_after_eop: rdy=%b required 1", rdy);
    end
    @(negedge clk);
    n_cmp++;
    if (rdy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_b_accept: rdy=%b required 0", rdy);
    end
    vld = 1'b0;
    rx(19, 1'b1);
    n_cmp++;
    if (got_n < 1 || got_t[0] - t_eop != SYNC_STAGES + 1) begin
      n_err++;
      $display("FAIL b2b_b_flit0_latency: %0d cycles required %0d", got_n < 1 ? -1 : got_t[0] - t_eop, SYNC_STAGES + 1);
    end
    n_cmp++;
    if (ra !== {32'h0, a[39:0]}) begin
      n_err++;
      $display("FAIL b2b_a_reasm: %h required %h", ra, {32'h0, a[39:0]});
    end
    n_cmp++;
    if (got_n != 19 || reasm(18) !== b || got[18] !== EOP) begin
      n_err++;
      $display("FAIL b2b_b_reasm: flits=%0d pkt=%h required 19/%h", got_n, reasm(18), b);
    end
  endtask
  task automatic test_reset_mid;
    logic [71:0] p, q;
    int acc, t;
    p = {32'h76543210, 32'hfedcba98, 8'h06};
    q = {32'h0, 32'h13579bdf, 8'h21};
    send_pkt(p, acc);
    rx(5, 1'b1);
    rst = 1'b1;
    ack = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sl !== 7'b0 || rdy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: data=%b rdy=%b required 0000000/0", sl, rdy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rdy !== 1'b0 || sl !== 7'b0) begin
      n_err++;
      $display("FAIL midreset_wait_link: rdy=%b data=%b required 0/0000000", rdy, sl);
    end
    ack = 1'b1;
    t = 0;
    while (!rdy && t < SYNC_STAGES + 2) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (rdy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_link_up: rdy=%b required 1", rdy);
    end
    send_pkt(q, acc);
    rx(11, 1'b1);
    n_cmp++;
    if (got_n != 11 || reasm(10) !== {32'h0, q[39:0]} || got[10] !== EOP) begin
      n_err++;
      $display("FAIL midreset_restart: flits=%0d pkt=%h required 11/%h", got_n, reasm(10), {32'h0, q[39:0]});
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    test_reset;
    test_short;
    test_long;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spio_spinnaker_link_synchronous_transmitter.md
# spio_spinnaker_link_synchronous_transmitter

Transmits 72-bit SpiNNaker packets over a SpiNNaker link using NRZ 2-of-7 flits with a transition-signalled acknowledge. It sits directly upstream of the link receiver: it consumes packets from a valid/ready packet interface and drives the 7 link data wires that the remote receiver decodes. The ack input is asynchronous to the transmitter clock.

## Interface
- SYNC_STAGES, 2, number of flip-flops in the ack synchronizer (minimum 2).
- CLK_IN  in  1  transmitter clock.
- RESET_IN  in  1  reset; synchronous, active-high.
- PKT_DATA_IN  in  72  packet fields:
  - [7:0] header; bit 1 = payload present.
  - [39:8] key.
  - [71:40] payload.
- PKT_VLD_IN  in  1  packet valid.
- PKT_RDY_OUT  out  1  ready to accept a packet.
- SL_DATA_2OF7_OUT  out  7  NRZ 2-of-7 link data wires.
- SL_ACK_IN  in  1  link ack; asynchronous, transition-signalled.

## Operation
- Packet buffer: one 72-bit register plus a full flag.
  - PKT_RDY_OUT = !full.
  - Transfer occurs when PKT_VLD_IN && PKT_RDY_OUT; the buffer loads and full is set.
- Flit order: nibbles LSB first, then an end-of-packet flit (EOP).
  - Nibble i = PKT_DATA_IN[4i +: 4].
  - Short packet (hdr[1]=0): nibbles 0..9, then EOP (11 flits).
  - Long packet (hdr[1]=1): nibbles 0..17, then EOP (19 flits).
  - Flit counter: 5 bits, range 0..18, reset to 0 after EOP.
- Encoding: the new wire value is the old wire value XOR a 2-hot symbol.
  - Symbols 0-3: 0010001, 0010010, 0010100, 0011000.
  - Symbols 4-7: 0100001, 0100010, 0100100, 0101000.
  - Symbols 8-11: 1000001, 1000010, 1000100, 1001000.
  - Symbols 12-15: 0000011, 0000110, 0001100, 0001001.
  - EOP: 1100000.
- Link flow control uses ack_ref (the expected ack level) and a busy flag.
  - ack_s is SL_ACK_IN after the SYNC_STAGES flip-flops.
  - When ack_s != ack_ref: busy is cleared and ack_ref takes the value of ack_s.
  - Exactly one flit is in flight per ack transition.
- FSM states:
  - WAIT_LINK (entered at reset): busy=1, ack_ref=0. Leaves when ack_s=1 (remote receiver ready); busy=0, ack_ref=1 → IDLE.
  - IDLE: if full, drive flit 0 and set busy → SEND. If not full, stay; the wires hold.
  - SEND: when busy clears, issue the next flit. Issuing EOP clears full, resets the counter, and moves to IDLE.
    - full is cleared in the same cycle EOP is issued, so a new packet can load while the EOP ack is pending.
    - The new packet's first flit issues the cycle busy clears.
- Simultaneous events:
  - Packet acceptance and EOP issue never coincide, because RDY=0 while full.
  - An ack arriving while not busy (spurious) still updates ack_ref but has no other effect.
- Reset mid-packet: the packet in flight is dropped and the FSM returns to WAIT_LINK.

## Timing
- Reset values:
  - SL_DATA_2OF7_OUT = 0000000.
  - PKT_RDY_OUT = 0 in WAIT_LINK, then 1 in IDLE.
  - Flit counter = 0, full = 0, ack_ref = 0.
- SL_DATA_2OF7_OUT is registered and changes only on a flit issue; exactly two bits toggle per flit.
- Acceptance at edge k → flit 0 appears at edge k+1 if not busy.
- An ack edge at SL_ACK_IN is visible in ack_s after SYNC_STAGES edges (plus up to one cycle of metastability window). The next flit appears on the following edge.
- Peak rate: one flit per (SYNC_STAGES + 1) cycles plus the link round-trip.
- PKT_RDY_OUT depends only on state and is not combinationally dependent on PKT_VLD_IN.

## Structure
- Shared package `spio_spinnaker_link_pkg`: 2-of-7 symbol table constants, EOP symbol, packet field ranges (HDR/KEY/PLD), flit counts (10/18).
- Sub-module `spio_spinnaker_link_ack_sync`: SYNC_STAGES-deep synchronizer. The FSM, counter, encoder and buffer stay in the top module.

## Test plan
- Reset, then ack held 0 for 20 cycles → RDY=0, data=0000000. Raise ack → RDY=1 within SYNC_STAGES+2 cycles.
- Short packet, hdr 0x00, key 0x00000001, ack toggled after each flit:
  - First flits: 0010001, 0000000, 0010010, 0000000, then alternating per the table.
  - 11 flits total; the last XOR is 1100000 (EOP).
- Long packet, hdr 0x02 + parity, payload 0xa5a5a5a5 → 19 flits. Nibbles 10..17 encode 5,a,5,a,5,a,5,a (LSB first).
- Ack withheld for 100 cycles mid-packet → data stable, no further flit issued. Resume → next flit appears SYNC_STAGES+1 cycles after the ack edge.
- Back-to-back packets with VLD held high → the second packet is accepted the cycle after EOP issue. Its flit 0 issues on the EOP ack with no idle flit; the receiver model reassembles both packets bit-exact.
- RESET_IN asserted at flit 5 → outputs return to reset values next edge, FSM in WAIT_LINK. After restart, the next packet is sent complete from flit 0.
